// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pipeline: VGA frame geometry,
// sprite-memory widths, layer indices and a small overlap helper.
package sprite_pkg;

    localparam int FRAME_X_LAST = 1055;
    localparam int FRAME_Y_LAST = 627;
    localparam int PIXEL_X_W    = 11;
    localparam int PIXEL_Y_W    = 10;

    localparam int ELEMENT_W    = 5;
    localparam int ADDR_W       = 10;

    // Layer 0 has the highest priority.
    typedef enum logic [1:0] {
        BARRIER = 2'd0,
        FRUIT   = 2'd1,
        HEART   = 2'd2,
        PLAYER  = 2'd3
    } layer_id_e;

    // True when two or more bits of v are set (clearing the lowest set
    // bit leaves something behind).
    function automatic logic is_multi(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/sprite_layer_mux_if.sv
// Pixel-side bus of the sprite layer multiplexer: per-layer requests and
// mask configuration in, selected sprite and collision summary out.
interface sprite_layer_mux_if #(
    parameter int LAYERS  = 4,
    parameter int ELEMENT = 5,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 16
);
    logic                        active;
    logic [sprite_pkg::PIXEL_X_W-1:0] pixel_x;
    logic [sprite_pkg::PIXEL_Y_W-1:0] pixel_y;
    logic [LAYERS-1:0]           layer_enable;
    logic [LAYERS*ELEMENT-1:0]   layer_element;
    logic [LAYERS*ADDR_W-1:0]    layer_address;
    logic                        cfg_we;
    logic [LAYERS-1:0]           cfg_mask;

    logic                        ready;
    logic [ELEMENT-1:0]          element;
    logic [ADDR_W-1:0]           address;
    logic [LAYERS-1:0]           winner;
    logic [LAYERS-1:0]           collision_flags;
    logic [CNT_W-1:0]            collision_count;
    logic                        frame_done;

    modport master (
        output active, pixel_x, pixel_y, layer_enable, layer_element,
               layer_address, cfg_we, cfg_mask,
        input  ready, element, address, winner, collision_flags,
               collision_count, frame_done
    );

    modport slave (
        input  active, pixel_x, pixel_y, layer_enable, layer_element,
               layer_address, cfg_we, cfg_mask,
        output ready, element, address, winner, collision_flags,
               collision_count, frame_done
    );
endinterface

// File: rtl/layer_priority_enc.sv
// Combinational lowest-index-wins one-hot encoder.
module layer_priority_enc #(
    parameter int LAYERS = 4
) (
    input  logic [LAYERS-1:0] req_i,
    output logic [LAYERS-1:0] grant_o,
    output logic              valid_o
);
    // Isolate the lowest set bit: req & -req.
    assign grant_o = req_i & (~req_i + LAYERS'(1));
    assign valid_o = |req_i;
endmodule

// File: rtl/sprite_layer_mux.sv
// Per-pixel sprite layer priority mux with runtime layer mask and
// per-frame collision (overlap) detection.
module sprite_layer_mux #(
    parameter int LAYERS       = 4,
    parameter int ELEMENT      = sprite_pkg::ELEMENT_W,
    parameter int ADDR_W       = sprite_pkg::ADDR_W,
    parameter int FRAME_X_LAST = sprite_pkg::FRAME_X_LAST,
    parameter int FRAME_Y_LAST = sprite_pkg::FRAME_Y_LAST,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    sprite_layer_mux_if.slave bus
);
    import sprite_pkg::is_multi;
    import sprite_pkg::PIXEL_X_W;
    import sprite_pkg::PIXEL_Y_W;

    logic [LAYERS-1:0]  mask_q;
    logic               ready_q;
    logic [LAYERS-1:0]  winner_q;
    logic [ELEMENT-1:0] element_q, element_d;
    logic [ADDR_W-1:0]  address_q, address_d;
    logic [LAYERS-1:0]  acc_flags_q, acc_flags_d;
    logic [CNT_W-1:0]   acc_count_q, acc_count_d;
    logic [LAYERS-1:0]  coll_flags_q;
    logic [CNT_W-1:0]   coll_count_q;
    logic               frame_done_q;

    logic [LAYERS-1:0]  eff;
    logic [LAYERS-1:0]  grant;
    logic               grant_valid;
    logic               overlap;
    logic               frame_end;

    assign eff = bus.layer_enable & mask_q & {LAYERS{bus.active}};

    layer_priority_enc #(.LAYERS(LAYERS)) u_enc (
        .req_i   (eff),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    assign overlap   = is_multi(32'(eff));
    assign frame_end = (bus.pixel_x == PIXEL_X_W'(FRAME_X_LAST)) &&
                       (bus.pixel_y == PIXEL_Y_W'(FRAME_Y_LAST));

    // Pick the winning layer's element/address; hold when nobody wins.
    always_comb begin
        element_d = element_q;
        address_d = address_q;
        for (int i = 0; i < LAYERS; i++) begin
            if (grant[i]) begin
                element_d = bus.layer_element[i*ELEMENT +: ELEMENT];
                address_d = bus.layer_address[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Accumulated overlap for the frame including the current pixel;
    // the count saturates instead of wrapping.
    always_comb begin
        acc_flags_d = acc_flags_q | (overlap ? eff : '0);
        acc_count_d = acc_count_q;
        if (overlap && (acc_count_q != {CNT_W{1'b1}}))
            acc_count_d = acc_count_q + CNT_W'(1);
    end

    // Mask register and registered selection outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '1;
            ready_q   <= 1'b0;
            winner_q  <= '0;
            element_q <= '0;
            address_q <= '0;
        end else begin
            if (bus.cfg_we)
                mask_q <= bus.cfg_mask;
            ready_q   <= grant_valid;
            winner_q  <= grant;
            element_q <= element_d;
            address_q <= address_d;
        end
    end

    // Collision accumulation and frame-end snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_flags_q  <= '0;
            acc_count_q  <= '0;
            coll_flags_q <= '0;
            coll_count_q <= '0;
            frame_done_q <= 1'b0;
        end else if (frame_end) begin
            coll_flags_q <= acc_flags_d;
            coll_count_q <= acc_count_d;
            acc_flags_q  <= '0;
            acc_count_q  <= '0;
            frame_done_q <= 1'b1;
        end else begin
            acc_flags_q  <= acc_flags_d;
            acc_count_q  <= acc_count_d;
            frame_done_q <= 1'b0;
        end
    end

    assign bus.ready           = ready_q;
    assign bus.winner          = winner_q;
    assign bus.element         = element_q;
    assign bus.address         = address_q;
    assign bus.collision_flags = coll_flags_q;
    assign bus.collision_count = coll_count_q;
    assign bus.frame_done      = frame_done_q;
endmodule

// File: tb/tb_sprite_layer_mux.sv
// Scoreboard bench for sprite_layer_mux (narrow collision counter so
// saturation is reachable).
module tb_sprite_layer_mux;
    localparam int L  = 4;
    localparam int E  = 5;
    localparam int A  = 10;
    localparam int CW = 4;
    localparam int XL = 1055;
    localparam int YL = 627;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_layer_mux_if #(.LAYERS(L), .ELEMENT(E), .ADDR_W(A), .CNT_W(CW)) bus ();

    sprite_layer_mux #(
        .LAYERS(L), .ELEMENT(E), .ADDR_W(A),
        .FRAME_X_LAST(XL), .FRAME_Y_LAST(YL), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic          ready;
        logic [L-1:0]  winner;
        logic [E-1:0]  element;
        logic [A-1:0]  address;
        logic          frame_done;
        logic [L-1:0]  flags;
        logic [CW-1:0] count;
    } pix_t;

    typedef struct {
        logic [L-1:0]  flags;
        logic [CW-1:0] count;
    } frm_t;

    pix_t exp_q[$];
    frm_t frm_q[$];
    int total = 0;
    int bad = 0;

    // Reference model state.
    logic [L-1:0]  m_mask;
    logic [E-1:0]  m_elem;
    logic [A-1:0]  m_addr;
    logic [L-1:0]  m_flags;
    int            m_pixels;
    logic [L-1:0]  m_cflags;
    logic [CW-1:0] m_ccount;

    task automatic model_reset();
        m_mask = '1; m_elem = '0; m_addr = '0;
        m_flags = '0; m_pixels = 0; m_cflags = '0; m_ccount = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive one pixel at the falling edge and push the model's prediction.
    task automatic drive(input logic act, input logic [L-1:0] en,
                         input logic [L*E-1:0] el, input logic [L*A-1:0] ad,
                         input int px, input int py,
                         input logic we, input logic [L-1:0] cm);
        pix_t r;
        frm_t f;
        logic [L-1:0] eff;
        bit found;
        int sat;
        @(negedge clk);
        bus.active = act; bus.layer_enable = en; bus.layer_element = el;
        bus.layer_address = ad; bus.pixel_x = 11'(px); bus.pixel_y = 10'(py);
        bus.cfg_we = we; bus.cfg_mask = cm;

        eff = act ? (en & m_mask) : '0;
        r.winner = '0;
        found = 0;
        for (int i = 0; i < L; i++) begin
            if (eff[i] && !found) begin
                found = 1;
                r.winner[i] = 1'b1;
                m_elem = el[i*E +: E];
                m_addr = ad[i*A +: A];
            end
        end
        r.ready = found;
        if ($countones(eff) >= 2) begin
            m_flags = m_flags | eff;
            m_pixels++;
        end
        r.frame_done = (px == XL) && (py == YL);
        if (r.frame_done) begin
            sat = (1 << CW) - 1;
            m_cflags = m_flags;
            m_ccount = CW'((m_pixels > sat) ? sat : m_pixels);
            m_flags = '0;
            m_pixels = 0;
            f.flags = m_cflags;
            f.count = m_ccount;
            frm_q.push_back(f);
        end
        r.element = m_elem;
        r.address = m_addr;
        r.flags = m_cflags;
        r.count = m_ccount;
        if (we) m_mask = cm;
        exp_q.push_back(r);
    endtask

    task automatic idle_inputs();
        bus.active = 1'b0; bus.layer_enable = '0; bus.layer_element = '0;
        bus.layer_address = '0; bus.pixel_x = '0; bus.pixel_y = '0;
        bus.cfg_we = 1'b0; bus.cfg_mask = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk); #2;
    endtask

    // Apply reset for a few cycles, checking outputs are cleared while held.
    task automatic do_reset(input string name);
        drain();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk); #1;
        check({name, "_outputs"},
              64'({bus.ready, bus.winner, bus.element, bus.address,
                   bus.collision_flags, bus.collision_count, bus.frame_done}),
              64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: one prediction per captured pixel, checked just after the edge.
    always begin
        pix_t r;
        frm_t f;
        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check("ready_winner", 64'({bus.ready, bus.winner}), 64'({r.ready, r.winner}));
            check("element_address", 64'({bus.element, bus.address}), 64'({r.element, r.address}));
            check("frame_done", 64'(bus.frame_done), 64'(r.frame_done));
            check("collision_out", 64'({bus.collision_flags, bus.collision_count}),
                  64'({r.flags, r.count}));
            if (bus.frame_done) begin
                if (frm_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL frame_unexpected: got frame_done=1 expected no frame");
                end else begin
                    f = frm_q.pop_front();
                    check("frame_snapshot", 64'({bus.collision_flags, bus.collision_count}),
                          64'({f.flags, f.count}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [L*E-1:0] el;
    logic [L*A-1:0] ad;

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_state",
              64'({bus.ready, bus.winner, bus.element, bus.address,
                   bus.collision_flags, bus.collision_count, bus.frame_done}),
              64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Priority: layers 1 and 3 request, layer 1 wins.
        el = 20'($urandom); el[1*E +: E] = 5'd5;
        ad = 40'({$urandom, $urandom}); ad[1*A +: A] = 10'h123;
        drive(1, 4'b1010, el, ad, 0, 0, 0, 0);
        drive(1, 4'b0000, el, ad, 1, 0, 0, 0);

        // Mask out layer 1, then layer 2 wins; then layer 1 alone loses.
        drive(1, 4'b0000, el, ad, 2, 0, 1, 4'b1101);
        el = 20'($urandom); ad = 40'({$urandom, $urandom});
        drive(1, 4'b0110, el, ad, 3, 0, 0, 0);
        drive(1, 4'b0010, 20'($urandom), 40'({$urandom, $urandom}), 4, 0, 0, 0);
        drive(1, 4'b0000, el, ad, 5, 0, 1, 4'b1111);

        // Inactive area: nothing wins, nothing accumulates.
        for (int i = 0; i < 3; i++)
            drive(0, 4'b1111, 20'($urandom), 40'({$urandom, $urandom}), 6 + i, 0, 0, 0);
        drive(0, 4'b0000, el, ad, XL, YL, 0, 0);

        // Collision frame: layers 0 and 3 overlap on 7 pixels.
        for (int i = 0; i < 7; i++)
            drive(1, 4'b1001, 20'($urandom), 40'({$urandom, $urandom}), 10 + i, 1, 0, 0);
        drive(1, 4'b0001, el, ad, 20, 1, 0, 0);
        drive(0, 4'b0000, el, ad, XL, YL, 0, 0);
        // Following frame with no overlap, frame-end with mask write.
        drive(1, 4'b0100, el, ad, 0, 0, 0, 0);
        drive(0, 4'b0000, el, ad, XL, YL, 1, 4'b1111);

        // Saturation: 20 overlap pixels, the last one on the frame-end pixel.
        for (int i = 0; i < 19; i++)
            drive(1, 4'b0110, 20'($urandom), 40'({$urandom, $urandom}), i, 2, 0, 0);
        drive(1, 4'b0110, el, ad, XL, YL, 0, 0);

        // Mid-frame reset: partial frame discarded, mask restored.
        drive(1, 4'b0000, el, ad, 0, 0, 1, 4'b0111);
        for (int i = 0; i < 3; i++)
            drive(1, 4'b1001, 20'($urandom), 40'({$urandom, $urandom}), i, 3, 0, 0);
        do_reset("mid_reset");
        drive(1, 4'b1000, 20'($urandom), 40'({$urandom, $urandom}), 0, 4, 0, 0);
        for (int i = 0; i < 2; i++)
            drive(1, 4'b1001, 20'($urandom), 40'({$urandom, $urandom}), 1 + i, 4, 0, 0);
        drive(0, 4'b0000, el, ad, XL, YL, 0, 0);

        // Randomised traffic with occasional frame ends and near-miss coordinates.
        for (int n = 0; n < 400; n++) begin
            int px, py, sel;
            sel = $urandom_range(0, 29);
            px = $urandom_range(0, 1000);
            py = $urandom_range(0, 600);
            if (sel == 0) begin px = XL; py = YL; end
            else if (sel == 1) begin px = XL; end
            else if (sel == 2) begin py = YL; end
            drive(($urandom_range(0, 7) != 0), 4'($urandom),
                  20'($urandom), 40'({$urandom, $urandom}), px, py,
                  ($urandom_range(0, 15) == 0), 4'($urandom));
        end
        drive(0, 4'b0000, el, ad, XL, YL, 0, 0);

        drain();
        total++;
        if (exp_q.size() != 0 || frm_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0",
                     exp_q.size(), frm_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
